ld_done_sequencer: RTL

// Initiator for the ld/done handshake of the round-counter block: accepts a job request,

---
 rtl/ld_done_sequencer_if.sv | 48 ++++
 rtl/ld_done_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ld_done_sequencer_if.sv
// Handshake bundle between the ld/done sequencer, its job source and the counter block.
// master: the sequencer side. slave: the job source / counter block / alarm logic side.
interface ld_done_sequencer_if #(
  parameter int unsigned FCNT_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              ld;
  logic              done;
  logic              rsp_valid;
  logic              rsp_ok;
  logic              rsp_ready;
  logic              busy;
  logic              clr_fault;
  logic              fault_flag;
  logic [1:0]        fault_code;
  logic [FCNT_W-1:0] fault_cnt;

  modport master (
    input  req_valid,
    output req_ready,
    output ld,
    input  done,
    output rsp_valid,
    output rsp_ok,
    input  rsp_ready,
    output busy,
    input  clr_fault,
    output fault_flag,
    output fault_code,
    output fault_cnt
  );

  modport slave (
    output req_valid,
    input  req_ready,
    input  ld,
    output done,
    input  rsp_valid,
    input  rsp_ok,
    output rsp_ready,
    input  busy,
    output clr_fault,
    input  fault_flag,
    input  fault_code,
    input  fault_cnt
  );
endinterface

// File: rtl/ld_done_sequencer.sv
// Initiator for the ld/done handshake of the round-counter block. Issues a one-cycle ld
// pulse per accepted job, then checks that done arrives exactly EXP_LAT cycles after the
// ld cycle. Early, late and spurious done are recorded as sticky fault status.
module ld_done_sequencer #(
  parameter int unsigned EXP_LAT       = 12,
  parameter bit          LOCK_ON_FAULT = 1'b1,
  parameter int unsigned FCNT_W        = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  ld_done_sequencer_if.master        io_bus
);

  localparam int unsigned CNT_W = $clog2(EXP_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(EXP_LAT);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_EARLY = 2'd1;
  localparam logic [1:0] FLT_LATE  = 2'd2;
  localparam logic [1:0] FLT_SPUR  = 2'd3;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ld;
  logic                r_rsp_valid;
  logic                r_rsp_ok;
  logic                r_fault_flag;
  logic [1:0]          r_fault_code;
  logic [FCNT_W-1:0]   r_fault_cnt;

  state_e              w_state_d;
  logic [CNT_W-1:0]    w_cnt_d;
  logic                w_ld_d;
  logic                w_rsp_valid_d;
  logic                w_rsp_ok_d;
  logic                w_fault_flag_d;
  logic [1:0]          w_fault_code_d;
  logic [FCNT_W-1:0]   w_fault_cnt_d;

  logic                w_req_ready;
  logic                w_accept;
  logic                w_fault_ev;
  logic [1:0]          w_fault_kind;

  // Only a new job is gated by the sticky fault; the rest of the FSM keeps running.
  assign w_req_ready = (r_state == StIdle) && !(LOCK_ON_FAULT && r_fault_flag);
  assign w_accept    = io_bus.req_valid && w_req_ready;

  // Job FSM: next state, shadow counter, ld pulse, response and fault event detection.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_ld_d        = 1'b0;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_ok_d    = r_rsp_ok;
    w_fault_ev    = 1'b0;
    w_fault_kind  = FLT_NONE;
    unique case (r_state)
      StIdle: begin
        if (io_bus.done) begin
          w_fault_ev   = 1'b1;
          w_fault_kind = FLT_SPUR;
        end
        if (w_accept) begin
          w_state_d = StLaunch;
          w_ld_d    = 1'b1;
          w_cnt_d   = '0;
        end
      end
      StLaunch: begin
        // Count 0: any done here is necessarily early.
        if (io_bus.done) begin
          w_fault_ev    = 1'b1;
          w_fault_kind  = FLT_EARLY;
          w_state_d     = StResp;
          w_rsp_valid_d = 1'b1;
          w_rsp_ok_d    = 1'b0;
        end else begin
          w_state_d = StWait;
          w_cnt_d   = CNT_W'(1);
        end
      end
      StWait: begin
        if (io_bus.done) begin
          w_state_d     = StResp;
          w_rsp_valid_d = 1'b1;
          if (r_cnt < LAT_C) begin
            w_fault_ev   = 1'b1;
            w_fault_kind = FLT_EARLY;
            w_rsp_ok_d   = 1'b0;
          end else begin
            w_rsp_ok_d = 1'b1;
          end
        end else if (r_cnt == LAT_C) begin
          w_fault_ev    = 1'b1;
          w_fault_kind  = FLT_LATE;
          w_state_d     = StResp;
          w_rsp_valid_d = 1'b1;
          w_rsp_ok_d    = 1'b0;
        end else if (r_cnt < LAT_C) begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StResp: begin
        // Trailing done (held too long or a stray pulse) leaves the pending result intact.
        if (io_bus.done) begin
          w_fault_ev   = 1'b1;
          w_fault_kind = FLT_SPUR;
        end
        if (r_rsp_valid && io_bus.rsp_ready) begin
          w_state_d     = StIdle;
          w_rsp_valid_d = 1'b0;
        end
      end
      default: begin
        w_state_d     = StIdle;
        w_rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Sticky fault status: a new fault beats a simultaneous clear; only the first code sticks.
  always_comb begin
    w_fault_flag_d = r_fault_flag;
    w_fault_code_d = r_fault_code;
    w_fault_cnt_d  = r_fault_cnt;
    if (w_fault_ev) begin
      w_fault_flag_d = 1'b1;
      if (!r_fault_flag || io_bus.clr_fault) begin
        w_fault_code_d = w_fault_kind;
      end
      if (r_fault_cnt != {FCNT_W{1'b1}}) begin
        w_fault_cnt_d = r_fault_cnt + FCNT_W'(1);
      end
    end else if (io_bus.clr_fault) begin
      w_fault_flag_d = 1'b0;
      w_fault_code_d = FLT_NONE;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_ld         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_ok     <= 1'b0;
      r_fault_flag <= 1'b0;
      r_fault_code <= FLT_NONE;
      r_fault_cnt  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_ld         <= w_ld_d;
      r_rsp_valid  <= w_rsp_valid_d;
      r_rsp_ok     <= w_rsp_ok_d;
      r_fault_flag <= w_fault_flag_d;
      r_fault_code <= w_fault_code_d;
      r_fault_cnt  <= w_fault_cnt_d;
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.busy       = (r_state != StIdle);
  assign io_bus.ld         = r_ld;
  assign io_bus.rsp_valid  = r_rsp_valid;
  assign io_bus.rsp_ok     = r_rsp_ok;
  assign io_bus.fault_flag = r_fault_flag;
  assign io_bus.fault_code = r_fault_code;
  assign io_bus.fault_cnt  = r_fault_cnt;

endmodule
